cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares one backing-memory port between `NUM_PORTS` cache controllers, for example the instruction cache and the data cache.
- Each requester issues line-sized reads (Allocate) and write-backs (WriteBack) with level-held `rd_en`/`wr_en` until it sees `ack`.
- The arbiter grants one requester at a time using round-robin priority.
- It forwards that requester's address, data and strobes to memory, and routes `mem_ack` back to the granted requester only.
- It sits between the cache controllers' memory interfaces and the system memory bus.

## Interface
- `NUM_PORTS`, default 2: number of requesters (≥2).
- `ADDR_SIZE`, default 32: memory address width.
- `DATA_SIZE`, default 128: line width in bits.
- `BYTE_NUM`, default `DATA_SIZE/8`: byte-select width.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_rd_en`  in  `[NUM_PORTS]`: per-port line read request.
- `req_wr_en`  in  `[NUM_PORTS]`: per-port line write request.
- `req_addr`  in  `[NUM_PORTS][ADDR_SIZE]`: per-port address.
- `req_wr_data`  in  `[NUM_PORTS][DATA_SIZE]`: per-port write line.
- `req_sel`  in  `[NUM_PORTS][BYTE_NUM]`: per-port byte select.
- `req_ack`  out  `[NUM_PORTS]`: completion, one-hot or zero.
- `req_rd_data`  out  `DATA_SIZE`: read line, broadcast to all ports.
- `mem_rd_en`, `mem_wr_en`  out  1: memory strobes.
- `mem_addr`  out  `ADDR_SIZE`: memory address.
- `mem_wr_data`  out  `DATA_SIZE`: memory write line.
- `mem_sel`  out  `BYTE_NUM`: memory byte select.
- `mem_ack`  in  1: memory completion.
- `mem_rd_data`  in  `DATA_SIZE`: memory read line.
- `busy`  out  1: a grant is active.
- `grant_id`  out  `$clog2(NUM_PORTS)`: index of the granted port; valid while `busy`.

## Operation
- State machine `{ArbIdle, ArbBusy}`, plus registers `grant_id` and `last_grant`.
- A port is "requesting" when `req_rd_en[i] | req_wr_en[i]`.
- ArbIdle:
  - All `mem_*` strobes and `req_ack` are 0, and `mem_ack` is ignored.
  - If any port is requesting, pick the first requesting index starting at `last_grant+1`, searching modulo `NUM_PORTS`.
  - Register that index into `grant_id` and go to ArbBusy.
- ArbBusy, with `g = grant_id`:
  - Outputs combinationally follow port g: `mem_rd_en = req_rd_en[g] & ~req_wr_en[g]`, `mem_wr_en = req_wr_en[g]`, and `mem_addr`/`mem_wr_data`/`mem_sel` come from port g.
  - A port asserting both strobes is treated as a write.
  - `req_ack[g] = mem_ack`; all other acks stay 0.
  - On `mem_ack`: `last_grant <= g`, go to ArbIdle.
  - If port g drops both strobes before ack (abort): go to ArbIdle, `last_grant <= g`, and assert no ack.
- `req_rd_data = mem_rd_data` at all times; a port qualifies it with its own `req_ack`.
- The grant is never pre-empted. Other ports' requests are held off until the current transaction completes or aborts.
- Arbitration only reads strobes; a port's address and data are not sampled until it is granted.

## Timing
- Reset (`reset`=0), taking effect immediately:
  - State ArbIdle, `last_grant = NUM_PORTS-1` (so port 0 wins first), `grant_id = 0`.
  - `busy`, `mem_rd_en`, `mem_wr_en` and `req_ack` are 0.
  - `mem_addr`, `mem_wr_data` and `mem_sel` are 0 (driven to 0 whenever not ArbBusy).
- Reset during ArbBusy drops the memory strobes asynchronously; the in-flight transaction is abandoned with no ack.
- Request at edge t with the arbiter in ArbIdle → `busy` and memory strobes high from edge t+1.
- `mem_ack` in cycle k → `req_ack[g]` high in the same cycle k, combinationally.
- ArbIdle is entered at k+1; at least one idle cycle always separates transactions. The earliest next strobe is k+2.
- Simultaneous requests in ArbIdle are resolved by round-robin. A port that just completed has lowest priority next round.
- `mem_ack` coincident with an abort in the same cycle counts as completion: ack is passed to port g.
- `mem_ack` while ArbIdle is ignored and does not change state.

## Structure
- Add `arb_state_t {ArbIdle, ArbBusy}` to `cache_pkg`. Grant index width is derived locally with `$clog2(NUM_PORTS)`.
- The natural sub-module is `rr_priority_picker`:
  - Parameter `NUM_PORTS`.
  - Inputs: request vector, `last_grant`.
  - Outputs: `valid`, `index`.
  - Purely combinational, and reusable by future bus arbiters.
- The FSM, registers and output muxing live in `cache_mem_arbiter`.

## Test plan
- Reset then idle: `reset` low mid-grant with port 1 writing → all strobes and acks 0 immediately; after release, requests from port 0 and port 1 together → port 0 is granted first.
- Single read: port 0 `rd_en`, addr 0x100, memory acks 3 cycles after the strobe with data 0xA5..A5 → `mem_rd_en` from t+1, addr 0x100, `req_ack[0]` in the same cycle as `mem_ack`, `req_rd_data` equals 0xA5..A5, `req_ack[1]` stays 0.
- Contention: ports 0 and 1 request continuously → grants alternate 0,1,0,1. Each transaction carries its own addr and data, with one idle cycle between them.
- Write-back then allocate: port 1 `wr_en` to addr 0x200 with `sel` all ones, acked; then port 1 `rd_en` to 0x300 with port 0 idle → write forwarded with data intact, then read granted at ack+2.
- Abort: port 0 drops `rd_en` in ArbBusy before any ack while port 1 is waiting → strobes low next cycle, no ack to port 0, port 1 granted one cycle later.
- Both strobes on port 1 → `mem_wr_en=1`, `mem_rd_en=0`; a spurious `mem_ack` in ArbIdle produces no `req_ack`.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache subsystem: controller-side and memory-side helpers.
package cache_pkg;

    typedef enum logic [0:0] {
        ArbIdle = 1'b0,
        ArbBusy = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: returns the first asserted request strictly after last_grant,
// wrapping modulo NUM_PORTS. Purely combinational.
module rr_priority_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic                 valid,
    output logic [IDX_W-1:0]     index
);

    int cand;

    // NOTE: every output gets a default before the search so no latch is inferred
    // when no request is present.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(last_grant) + k) % NUM_PORTS;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one backing-memory port between NUM_PORTS cache controllers using
// non-preemptive round-robin grants; the granted port drives memory combinationally.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 128,
    parameter int BYTE_NUM  = DATA_SIZE / 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_PORTS-1:0]                   req_rd_en,
    input  logic [NUM_PORTS-1:0]                   req_wr_en,
    input  logic [NUM_PORTS-1:0][ADDR_SIZE-1:0]    req_addr,
    input  logic [NUM_PORTS-1:0][DATA_SIZE-1:0]    req_wr_data,
    input  logic [NUM_PORTS-1:0][BYTE_NUM-1:0]     req_sel,
    output logic [NUM_PORTS-1:0]                   req_ack,
    output logic [DATA_SIZE-1:0]                   req_rd_data,
    output logic                                   mem_rd_en,
    output logic                                   mem_wr_en,
    output logic [ADDR_SIZE-1:0]                   mem_addr,
    output logic [DATA_SIZE-1:0]                   mem_wr_data,
    output logic [BYTE_NUM-1:0]                    mem_sel,
    input  logic                                   mem_ack,
    input  logic [DATA_SIZE-1:0]                   mem_rd_data,
    output logic                                   busy,
    output logic [$clog2(NUM_PORTS)-1:0]           grant_id
);

    localparam int GW = $clog2(NUM_PORTS);

    arb_state_t             state;
    logic [GW-1:0]          last_grant;
    logic [NUM_PORTS-1:0]   req_vec;
    logic                   pick_valid;
    logic [GW-1:0]          pick_index;
    logic                   grant_active;

    assign req_vec      = req_rd_en | req_wr_en;
    assign grant_active = req_vec[grant_id];

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (GW)
    ) u_picker (
        .req        (req_vec),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ArbIdle;
            last_grant <= GW'(NUM_PORTS - 1);
            grant_id   <= '0;
        end else begin
            case (state)
                ArbIdle: begin
                    if (pick_valid) begin
                        grant_id <= pick_index;
                        state    <= ArbBusy;
                    end
                end
                ArbBusy: begin
                    // Completion and abort both release the grant; ack wins if coincident.
                    if (mem_ack || !grant_active) begin
                        last_grant <= grant_id;
                        state      <= ArbIdle;
                    end
                end
                default: state <= ArbIdle;
            endcase
        end
    end

    assign busy        = (state == ArbBusy);
    assign req_rd_data = mem_rd_data;

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_sel     = '0;
        req_ack     = '0;
        if (busy) begin
            mem_rd_en         = req_rd_en[grant_id] & ~req_wr_en[grant_id];
            mem_wr_en         = req_wr_en[grant_id];
            mem_addr          = req_addr[grant_id];
            mem_wr_data       = req_wr_data[grant_id];
            mem_sel           = req_sel[grant_id];
            req_ack[grant_id] = mem_ack;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected grants/acks are queued by the
// stimulus and popped by a negedge monitor; a latency-programmable memory responds.
module tb_cache_mem_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int BN = 16;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [NP-1:0]          req_rd_en;
    logic [NP-1:0]          req_wr_en;
    logic [NP-1:0][AW-1:0]  req_addr;
    logic [NP-1:0][DW-1:0]  req_wr_data;
    logic [NP-1:0][BN-1:0]  req_sel;
    logic [NP-1:0]          req_ack;
    logic [DW-1:0]          req_rd_data;
    logic                   mem_rd_en;
    logic                   mem_wr_en;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wr_data;
    logic [BN-1:0]          mem_sel;
    logic                   mem_ack;
    logic [DW-1:0]          mem_rd_data;
    logic                   busy;
    logic [0:0]             grant_id;

    cache_mem_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .BYTE_NUM  (BN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_rd_en   (req_rd_en),
        .req_wr_en   (req_wr_en),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_sel     (req_sel),
        .req_ack     (req_ack),
        .req_rd_data (req_rd_data),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_sel     (mem_sel),
        .mem_ack     (mem_ack),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [127:0] data;
        logic [15:0] sel;
    } grant_t;

    typedef struct {
        int           port;
        logic         rd;
        logic [127:0] rdata;
    } ack_t;

    grant_t grant_q[$];
    ack_t   ack_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_for(input logic [31:0] a);
        if (a == 32'h100) return {16{8'hA5}};
        return {4{a ^ 32'hC0DE_0000}};
    endfunction

    // Memory responder: acks `lat` cycles after the first strobe cycle.
    int lat     = 1;
    bit resp_en = 1'b1;
    int rcnt    = 0;
    always @(posedge clock) begin
        #2;
        if (resp_en) begin
            if (mem_rd_en || mem_wr_en) begin
                if (rcnt == lat) begin
                    mem_ack     = 1'b1;
                    mem_rd_data = line_for(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                end
                rcnt++;
            end else begin
                mem_ack = 1'b0;
                rcnt    = 0;
            end
        end
    end

    // Monitor: checks each new grant and each ack against the scoreboard queues.
    logic   prev_busy = 1'b0;
    grant_t ge;
    ack_t   ae;
    logic [NP-1:0] ack_exp;
    always @(negedge clock) begin
        if (reset) begin
            if (busy && !prev_busy) begin
                if (grant_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL grant_unexpected: got grant to port %0d expected none", grant_id);
                end else begin
                    ge = grant_q.pop_front();
                    check("grant_id", grant_id, ge.port);
                    check("mem_rd_en", mem_rd_en, ge.rd);
                    check("mem_wr_en", mem_wr_en, ge.wr);
                    check("mem_addr", mem_addr, ge.addr);
                    check("mem_wr_data", mem_wr_data, ge.data);
                    check("mem_sel", mem_sel, ge.sel);
                end
            end
            if (req_ack != '0) begin
                if (ack_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL ack_unexpected: got req_ack %b expected 00", req_ack);
                end else begin
                    ae      = ack_q.pop_front();
                    ack_exp = NP'(1) << ae.port;
                    check("req_ack", req_ack, ack_exp);
                    if (ae.rd) check("req_rd_data", req_rd_data, ae.rdata);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int p, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [127:0] d, input logic [15:0] s);
        req_rd_en[p]   = rd;
        req_wr_en[p]   = wr;
        req_addr[p]    = a;
        req_wr_data[p] = d;
        req_sel[p]     = s;
    endtask

    task automatic exp_grant(input int p, input logic rd, input logic wr, input logic [31:0] a,
                             input logic [127:0] d, input logic [15:0] s);
        grant_q.push_back('{port: p, rd: rd, wr: wr, addr: a, data: d, sel: s});
    endtask

    task automatic exp_ack(input int p, input logic rd, input logic [31:0] a);
        ack_q.push_back('{port: p, rd: rd, rdata: line_for(a)});
    endtask

    task automatic wait_ack(input int p, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            if (req_ack[p]) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL ack_timeout: port %0d got no ack expected one within 60 cycles", p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t;
        int st;
        int a;
        logic [127:0] w1;
        logic [127:0] w2;
        logic [127:0] w3;
        w1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        w2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE;
        w3 = 128'h0F0F_0F0F_A0A0_A0A0_5555_AAAA_C3C3_3C3C;

        req_rd_en   = '0;
        req_wr_en   = '0;
        req_addr    = '0;
        req_wr_data = '0;
        req_sel     = '0;
        mem_ack     = 1'b0;
        mem_rd_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_mem_strobes", {mem_rd_en, mem_wr_en}, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1'b1;
        tick();

        // Reset mid-grant while port 1 writes.
        lat = 20;
        exp_grant(1, 1'b0, 1'b1, 32'h400, w1, 16'hFFFF);
        set_req(1, 1'b0, 1'b1, 32'h400, w1, 16'hFFFF);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_mem_wr_en", mem_wr_en, 0);
        check("midrst_mem_rd_en", mem_rd_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req_ack", req_ack, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wr_data", mem_wr_data, 0);
        set_req(1, 1'b0, 1'b0, 32'h0, '0, '0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Simultaneous requests after reset: port 0 wins first.
        lat = 1;
        exp_grant(0, 1'b1, 1'b0, 32'h10, '0, 16'hFFFF);
        exp_grant(1, 1'b1, 1'b0, 32'h20, '0, 16'hFFFF);
        exp_ack(0, 1'b1, 32'h10);
        exp_ack(1, 1'b1, 32'h20);
        set_req(0, 1'b1, 1'b0, 32'h10, '0, 16'hFFFF);
        set_req(1, 1'b1, 1'b0, 32'h20, '0, 16'hFFFF);
        wait_ack(0, t);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, '0, '0);
        wait_ack(1, t);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0, '0, '0);
        tick();

        // Single read, memory acks 3 cycles after the strobe.
        lat = 3;
        exp_grant(0, 1'b1, 1'b0, 32'h100, '0, 16'hFFFF);
        exp_ack(0, 1'b1, 32'h100);
        set_req(0, 1'b1, 1'b0, 32'h100, '0, 16'hFFFF);
        tick();
        @(negedge clock);
        st = cyc;
        check("rd_strobe_t1", mem_rd_en, 1);
        check("rd_addr_t1", mem_addr, 32'h100);
        wait_ack(0, t);
        check("rd_ack_latency", t - st, 3);
        check("rd_data_a5", req_rd_data, {16{8'hA5}});
        check("rd_ack_port1_low", req_ack[1], 0);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, '0, '0);
        tick();

        // Write-back then allocate on port 1.
        lat = 1;
        exp_grant(1, 1'b0, 1'b1, 32'h200, w2, 16'hFFFF);
        exp_ack(1, 1'b0, 32'h200);
        set_req(1, 1'b0, 1'b1, 32'h200, w2, 16'hFFFF);
        wait_ack(1, t);
        tick();
        exp_grant(1, 1'b1, 1'b0, 32'h300, '0, 16'hFFFF);
        exp_ack(1, 1'b1, 32'h300);
        set_req(1, 1'b1, 1'b0, 32'h300, '0, 16'hFFFF);
        @(negedge clock);
        check("wb_idle_gap_busy", busy, 0);
        check("wb_idle_gap_rd", mem_rd_en, 0);
        @(negedge clock);
        check("alloc_rd_en", mem_rd_en, 1);
        check("alloc_at_ack_plus2", cyc - t, 2);
        wait_ack(1, t);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0, '0, '0);
        tick();

        // Contention: both ports request continuously; grants alternate 0,1,0,1.
        exp_grant(0, 1'b1, 1'b0, 32'h1000, '0, 16'hFFFF);
        exp_grant(1, 1'b0, 1'b1, 32'h2000, {4{32'h2000}}, 16'h0FF0);
        exp_grant(0, 1'b1, 1'b0, 32'h1010, '0, 16'hFFFF);
        exp_grant(1, 1'b0, 1'b1, 32'h2010, {4{32'h2010}}, 16'hF00F);
        exp_ack(0, 1'b1, 32'h1000);
        exp_ack(1, 1'b0, 32'h2000);
        exp_ack(0, 1'b1, 32'h1010);
        exp_ack(1, 1'b0, 32'h2010);
        set_req(0, 1'b1, 1'b0, 32'h1000, '0, 16'hFFFF);
        set_req(1, 1'b0, 1'b1, 32'h2000, {4{32'h2000}}, 16'h0FF0);
        wait_ack(0, t);
        tick();
        set_req(0, 1'b1, 1'b0, 32'h1010, '0, 16'hFFFF);
        wait_ack(1, t);
        tick();
        set_req(1, 1'b0, 1'b1, 32'h2010, {4{32'h2010}}, 16'hF00F);
        wait_ack(0, t);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, '0, '0);
        wait_ack(1, t);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0, '0, '0);
        tick();

        // Abort: port 0 drops its read while port 1 waits.
        lat = 50;
        exp_grant(0, 1'b1, 1'b0, 32'h500, '0, 16'hFFFF);
        exp_grant(1, 1'b1, 1'b0, 32'h600, '0, 16'hFFFF);
        exp_ack(1, 1'b1, 32'h600);
        set_req(0, 1'b1, 1'b0, 32'h500, '0, 16'hFFFF);
        set_req(1, 1'b1, 1'b0, 32'h600, '0, 16'hFFFF);
        tick();
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, '0, '0);
        lat = 2;
        a   = cyc;
        @(negedge clock);
        check("abort_strobe_low", mem_rd_en, 0);
        check("abort_no_ack", req_ack, 0);
        wait_ack(1, t);
        check("abort_regrant_ack_cycle", t - a, 4);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0, '0, '0);
        tick();

        // Both strobes on port 1 are a write.
        lat = 1;
        exp_grant(1, 1'b0, 1'b1, 32'h700, w3, 16'h00F0);
        exp_ack(1, 1'b0, 32'h700);
        set_req(1, 1'b1, 1'b1, 32'h700, w3, 16'h00F0);
        tick();
        @(negedge clock);
        check("both_wr_en", mem_wr_en, 1);
        check("both_rd_en", mem_rd_en, 0);
        wait_ack(1, t);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0, '0, '0);
        tick();

        // Spurious mem_ack while idle.
        resp_en = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("spurious_req_ack", req_ack, 0);
            check("spurious_busy", busy, 0);
        end
        tick();
        mem_ack = 1'b0;
        resp_en = 1'b1;
        tick();
        @(negedge clock);
        check("spurious_still_idle", busy, 0);

        check("grant_q_drained", grant_q.size(), 0);
        check("ack_q_drained", ack_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
